// File: rtl/e1cnt_ram_acc.sv
// e1cnt_ram_acc: per-channel counter accumulator driving an external
// true dual-port RAM (port A read-only, port B write-only), one
// read-modify-write per cycle, for the E1 tributary error counters.
// The CPU reads, or reads and clears, a counter through cpu_req/cpu_ack.
// After reset the whole RAM is cleared by a write sweep on port B.
// Build option: define E1CNT_SAT_EN to saturate counters at 2^WIDTH-1
// instead of wrapping.
module e1cnt_ram_acc #(
    parameter int ADDRBIT = 5,
    parameter int DEPTH   = 21,
    parameter int WIDTH   = 16,
    parameter int INCW    = 4
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               inc_vld,
    input  logic [ADDRBIT-1:0] inc_ch,
    input  logic [INCW-1:0]    inc_val,
    input  logic               cpu_req,
    input  logic [ADDRBIT-1:0] cpu_addr,
    input  logic               cpu_clr,
    output logic               cpu_ack,
    output logic [WIDTH-1:0]   cpu_rdat,
    output logic               init_busy,
    output logic               drop_err,
    output logic [ADDRBIT-1:0] ra_a,
    output logic               ra_we,
    input  logic [WIDTH-1:0]   ra_do,
    output logic [ADDRBIT-1:0] rb_a,
    output logic               rb_we,
    output logic [WIDTH-1:0]   rb_di
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam logic [ADDRBIT-1:0] LAST_IDX = ADDRBIT'(DEPTH - 1);

    state_t             state, state_nxt;
    logic [ADDRBIT-1:0] init_cnt;

    // Stage P1: operation whose read data arrives this cycle.
    logic               p1_vld;
    logic               p1_inc;     // 1 = increment, 0 = CPU access
    logic               p1_clr;
    logic [ADDRBIT-1:0] p1_a;
    logic [INCW-1:0]    p1_val;

    // Stage P2: the write committed at the previous edge, for forwarding.
    logic               p2_vld;
    logic [ADDRBIT-1:0] p2_a;
    logic [WIDTH-1:0]   p2_data;

    logic               cpu_busy;
    logic               issue_inc;
    logic               issue_cpu;
    logic [WIDTH-1:0]   cur;
    logic [WIDTH-1:0]   sum;

    // State register and clear-sweep counter.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT)
                init_cnt <= init_cnt + ADDRBIT'(1);
        end
    end

    // Leave the sweep once the last counter entry is being written.
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && init_cnt == LAST_IDX)
            state_nxt = ST_RUN;
    end

    // A CPU op is in flight from its P1 cycle through its ack cycle.
    assign cpu_busy  = (p1_vld && !p1_inc) || cpu_ack;
    assign issue_inc = (state == ST_RUN) && inc_vld;
    assign issue_cpu = (state == ST_RUN) && !inc_vld && cpu_req && !cpu_busy;

    assign ra_a      = issue_cpu ? cpu_addr : inc_ch;
    assign ra_we     = 1'b0;
    assign init_busy = (state == ST_INIT);

    // Current counter value: the RAM returns pre-write data when the
    // previous op wrote the same entry at the read edge, so forward it.
    always_comb begin
        cur = ra_do;
        if (p2_vld && p2_a == p1_a)
            cur = p2_data;
    end

    // Counter update, wrapping or saturating depending on the build.
    always_comb begin
`ifdef E1CNT_SAT_EN
        logic [WIDTH:0] wide;
        wide = {1'b0, cur} + {{(WIDTH + 1 - INCW){1'b0}}, p1_val};
        sum  = wide[WIDTH] ? {WIDTH{1'b1}} : wide[WIDTH-1:0];
`else
        sum = cur + {{(WIDTH - INCW){1'b0}}, p1_val};
`endif
    end

    // Port B: clear sweep during init, otherwise the P1 write-back.
    always_comb begin
        rb_we = 1'b0;
        rb_a  = p1_a;
        rb_di = '0;
        if (state == ST_INIT) begin
            rb_we = 1'b1;
            rb_a  = init_cnt;
        end else if (p1_vld) begin
            if (p1_inc) begin
                rb_we = 1'b1;
                rb_di = sum;
            end else begin
                rb_we = p1_clr;
            end
        end
    end

    // Issue stage into P1.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            p1_vld <= 1'b0;
            p1_inc <= 1'b0;
            p1_clr <= 1'b0;
            p1_a   <= '0;
            p1_val <= '0;
        end else begin
            p1_vld <= issue_inc || issue_cpu;
            p1_inc <= issue_inc;
            p1_clr <= cpu_clr;
            p1_a   <= ra_a;
            p1_val <= inc_val;
        end
    end

    // P2 records what P1 wrote, for forwarding into the next op.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            p2_vld  <= 1'b0;
            p2_a    <= '0;
            p2_data <= '0;
        end else begin
            p2_vld  <= p1_vld && rb_we;
            p2_a    <= rb_a;
            p2_data <= rb_di;
        end
    end

    // CPU response: read data captured from the P1 current value.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cpu_ack  <= 1'b0;
            cpu_rdat <= '0;
        end else begin
            cpu_ack <= p1_vld && !p1_inc;
            if (p1_vld && !p1_inc)
                cpu_rdat <= cur;
        end
    end

    // Sticky flag for increments lost during the clear sweep.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)
            drop_err <= 1'b0;
        else if (state == ST_INIT && inc_vld)
            drop_err <= 1'b1;
    end

endmodule
